// File: rtl/vga_pkg.sv
// Shared VGA definitions: RGB332 field layout, default 640x480@60 timing,
// and the helper that locates one sprite's slice inside a packed bus.
package vga_pkg;

    localparam int RGB_R_W = 3;
    localparam int RGB_G_W = 3;
    localparam int RGB_B_W = 2;
    localparam int RGB_W   = RGB_R_W + RGB_G_W + RGB_B_W;

    typedef struct packed {
        logic [RGB_R_W-1:0] r;
        logic [RGB_G_W-1:0] g;
        logic [RGB_B_W-1:0] b;
    } rgb332_t;

    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_H_FP        = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BP        = 48;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_V_FP        = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BP        = 29;
    localparam int DEF_NUM_SPRITES = 4;
    localparam int DEF_COORD_W     = 11;

    // Bit offset of sprite idx within a bus packed as width bits per sprite.
    function automatic int sprite_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster timing: pixel/line counters, raw active-low syncs, visible flag,
// active-area pixel coordinates and the top-of-frame flag.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int COORD_W  = DEF_COORD_W
) (
    input  logic               i_dclk,
    input  logic               i_clr,
    output logic               o_hsync_raw,
    output logic               o_vsync_raw,
    output logic               o_visible,
    output logic               o_frame,
    output logic [COORD_W-1:0] o_px,
    output logic [COORD_W-1:0] o_py
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    // Counters must hold every position of a line/frame without wrapping early.
    if (H_TOTAL >= (1 << COORD_W)) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL does not fit in COORD_W bits");
    end
    if (V_TOTAL >= (1 << COORD_W)) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL does not fit in COORD_W bits");
    end

    localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_SYNC_C  = COORD_W'(H_SYNC);
    localparam logic [COORD_W-1:0] V_SYNC_C  = COORD_W'(V_SYNC);
    localparam logic [COORD_W-1:0] H_VIS_BEG = COORD_W'(H_SYNC + H_BP);
    localparam logic [COORD_W-1:0] H_VIS_END = COORD_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS_BEG = COORD_W'(V_SYNC + V_BP);
    localparam logic [COORD_W-1:0] V_VIS_END = COORD_W'(V_SYNC + V_BP + V_ACTIVE);

    logic [COORD_W-1:0] r_hc;
    logic [COORD_W-1:0] r_vc;

    // Pixel counter wraps every line; the line counter steps only on that wrap.
    always_ff @(posedge i_dclk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (i_clr) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (r_hc == H_LAST) begin
            r_hc <= '0;
            r_vc <= (r_vc == V_LAST) ? '0 : r_vc + COORD_W'(1);
        end else begin
            r_hc <= r_hc + COORD_W'(1);
        end
    end

    // Line order is sync, back porch, active, front porch.
    assign o_hsync_raw = (r_hc >= H_SYNC_C);
    assign o_vsync_raw = (r_vc >= V_SYNC_C);
    assign o_visible   = (r_hc >= H_VIS_BEG) && (r_hc < H_VIS_END) &&
                         (r_vc >= V_VIS_BEG) && (r_vc < V_VIS_END);
    assign o_frame     = (r_hc == '0) && (r_vc == '0);
    assign o_px        = r_hc - H_VIS_BEG;
    assign o_py        = r_vc - V_VIS_BEG;

endmodule

// File: rtl/vga_sprite_renderer.sv
// Rectangle-sprite VGA renderer: per-frame shadowed sprite set, priority
// hit test (lowest index wins) and a 2-stage output pipeline.
module vga_sprite_renderer
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int NUM_SPRITES = DEF_NUM_SPRITES,
    parameter int COORD_W     = DEF_COORD_W
) (
    input  logic                           dclk,
    input  logic                           clr,
    input  logic [NUM_SPRITES-1:0]         sprite_en,
    input  logic [NUM_SPRITES*COORD_W-1:0] sprite_x,
    input  logic [NUM_SPRITES*COORD_W-1:0] sprite_y,
    input  logic [NUM_SPRITES*COORD_W-1:0] sprite_x_end,
    input  logic [NUM_SPRITES*COORD_W-1:0] sprite_y_end,
    input  logic [NUM_SPRITES*RGB_W-1:0]   sprite_rgb,
    input  logic [RGB_W-1:0]               bg_rgb,
    output logic                           hsync,
    output logic                           vsync,
    output logic [RGB_R_W-1:0]             red,
    output logic [RGB_G_W-1:0]             green,
    output logic [RGB_B_W-1:0]             blue,
    output logic                           frame_start,
    output logic                           active
);

    if (NUM_SPRITES < 1 || NUM_SPRITES > 16) begin : g_bad_num_sprites
        $error("vga_sprite_renderer: NUM_SPRITES must be 1..16");
    end

    logic               w_hsync_raw;
    logic               w_vsync_raw;
    logic               w_visible;
    logic               w_frame;
    logic [COORD_W-1:0] w_px;
    logic [COORD_W-1:0] w_py;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .COORD_W (COORD_W)
    ) u_timing (
        .i_dclk     (dclk),
        .i_clr      (clr),
        .o_hsync_raw(w_hsync_raw),
        .o_vsync_raw(w_vsync_raw),
        .o_visible  (w_visible),
        .o_frame    (w_frame),
        .o_px       (w_px),
        .o_py       (w_py)
    );

    // Shadow copy of the sprite set; reloaded only at counter position (0,0),
    // which is also the first cycle after clr releases.
    logic [NUM_SPRITES-1:0]         r_sh_en;
    logic [NUM_SPRITES*COORD_W-1:0] r_sh_x;
    logic [NUM_SPRITES*COORD_W-1:0] r_sh_y;
    logic [NUM_SPRITES*COORD_W-1:0] r_sh_x_end;
    logic [NUM_SPRITES*COORD_W-1:0] r_sh_y_end;
    logic [NUM_SPRITES*RGB_W-1:0]   r_sh_rgb;

    // Shadow enables: cleared by clr, reloaded at the top of each frame.
    always_ff @(posedge dclk) begin
        if (clr) begin
            r_sh_en <= '0;
        end else if (w_frame) begin
            r_sh_en <= sprite_en;
        end
    end

    // Shadow bounds and colors, reloaded alongside the enables.
    always_ff @(posedge dclk) begin
        // NOTE: no reset on this wide data; the cleared enables mask it until the first reload.
        if (w_frame) begin
            r_sh_x     <= sprite_x;
            r_sh_y     <= sprite_y;
            r_sh_x_end <= sprite_x_end;
            r_sh_y_end <= sprite_y_end;
            r_sh_rgb   <= sprite_rgb;
        end
    end

    logic [NUM_SPRITES-1:0] w_hit;

    // Inclusive rectangle test per sprite; inverted bounds can never match.
    always_comb begin
        // NOTE: default assigned first so no path leaves w_hit unassigned (no latch).
        w_hit = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            w_hit[i] = r_sh_en[i] &&
                       (w_px >= r_sh_x    [sprite_lsb(i, COORD_W) +: COORD_W]) &&
                       (w_px <= r_sh_x_end[sprite_lsb(i, COORD_W) +: COORD_W]) &&
                       (w_py >= r_sh_y    [sprite_lsb(i, COORD_W) +: COORD_W]) &&
                       (w_py <= r_sh_y_end[sprite_lsb(i, COORD_W) +: COORD_W]);
        end
    end

    logic [NUM_SPRITES-1:0] r_s1_hit;
    logic                   r_s1_vis;
    logic                   r_s1_hs;
    logic                   r_s1_vs;
    logic                   r_s1_frame;
    logic [RGB_W-1:0]       r_s1_bg;

    // Stage 1: hit vector, visibility, raw syncs, frame flag and background color.
    always_ff @(posedge dclk) begin
        if (clr) begin
            r_s1_hit   <= '0;
            r_s1_vis   <= 1'b0;
            r_s1_hs    <= 1'b1;
            r_s1_vs    <= 1'b1;
            r_s1_frame <= 1'b0;
            r_s1_bg    <= '0;
        end else begin
            r_s1_hit   <= w_hit;
            r_s1_vis   <= w_visible;
            r_s1_hs    <= w_hsync_raw;
            r_s1_vs    <= w_vsync_raw;
            r_s1_frame <= w_frame;
            r_s1_bg    <= bg_rgb;
        end
    end

    rgb332_t w_color;

    // Priority pick: lowest-index hit wins, background otherwise, black in blanking.
    always_comb begin
        w_color = rgb332_t'(r_s1_bg);
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (r_s1_hit[i]) begin
                w_color = rgb332_t'(r_sh_rgb[sprite_lsb(i, RGB_W) +: RGB_W]);
            end
        end
        if (!r_s1_vis) begin
            w_color = '0;
        end
    end

    logic    r_hsync;
    logic    r_vsync;
    rgb332_t r_color;
    logic    r_frame_start;
    logic    r_active;

    // Stage 2: registered color plus syncs and flags delayed to match.
    always_ff @(posedge dclk) begin
        if (clr) begin
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_color       <= '0;
            r_frame_start <= 1'b0;
            r_active      <= 1'b0;
        end else begin
            r_hsync       <= r_s1_hs;
            r_vsync       <= r_s1_vs;
            r_color       <= w_color;
            r_frame_start <= r_s1_frame;
            r_active      <= r_s1_vis;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign red         = r_color.r;
    assign green       = r_color.g;
    assign blue        = r_color.b;
    assign frame_start = r_frame_start;
    assign active      = r_active;

endmodule

// File: doc/vga_sprite_renderer.md
VGA_SPRITE_RENDERER -- requirements
Module: vga_sprite_renderer

Interface
REQ-001 SHALL provide parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL provide parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL provide parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 SHALL provide parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL provide parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 29 as defaults, the vertical equivalents in lines.
REQ-006 SHALL provide parameter NUM_SPRITES, default 4, number of rectangle sprites (1..16).
REQ-007 SHALL provide parameter COORD_W, default 11, coordinate width in bits.
REQ-008 SHALL have ports as follows:
- dclk  in  1  pixel clock.
- clr  in  1  reset; one clock, synchronous, active-high.
- sprite_en  in  NUM_SPRITES  per-sprite enable.
- sprite_x, sprite_y, sprite_x_end, sprite_y_end  in  NUM_SPRITES*COORD_W each  packed inclusive bounds, active-pixel space; sprite i occupies bits [COORD_W*i +: COORD_W].
- sprite_rgb  in  NUM_SPRITES*8  packed RGB332 color per sprite.
- bg_rgb  in  8  background RGB332 color.
- hsync, vsync  out  1 each  active-low sync.
- red  out  3; green  out  3; blue  out  2  pixel color.
- frame_start  out  1  one-cycle pulse.
- active  out  1  high while the output pixel is visible.

Function
REQ-009 SHALL count hc 0..H_TOTAL-1 (H_TOTAL = sum of the four H parameters), wrapping to 0, and count vc 0..V_TOTAL-1, advancing vc only when hc wraps and wrapping vc to 0 after V_TOTAL-1.
REQ-010 SHALL order each line as sync, back porch, active, front porch. Raw hsync is low iff hc < H_SYNC. Raw vsync is low iff vc < V_SYNC.
REQ-011 SHALL treat a pixel as visible iff hc is in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and vc is in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE). Pixel coordinate: px = hc-(H_SYNC+H_BP), py = vc-(V_SYNC+V_BP).
REQ-012 SHALL latch all sprite_* inputs into shadow registers on the cycle where hc==0 and vc==0, and on the first cycle after clr deasserts. Input changes at any other time SHALL NOT affect the current frame.
REQ-013 SHALL declare sprite i hit iff shadow en[i] is set and sx<=px<=sx_end and sy<=py<=sy_end, compared unsigned at COORD_W bits. If sx_end<sx or sy_end<sy, sprite i SHALL never hit.
REQ-014 SHALL run a 2-stage pipeline: stage 1 registers the hit vector, visible flag, raw syncs and frame flag; stage 2 registers the color and delayed syncs. All outputs lag the counters by exactly 2 cycles.
REQ-015 SHALL output, for a visible pixel, the color of the lowest-index hit sprite, or bg_rgb if no sprite hits. bg_rgb is sampled at stage 1, not shadowed.
REQ-016 SHALL drive red, green and blue to 0 whenever the pixel is not visible.
REQ-017 SHALL assert frame_start for exactly one cycle, aligned with the output of counter position (0,0).
REQ-018 SHALL require H_TOTAL < 2**COORD_W and V_TOTAL < 2**COORD_W; a violating parameterisation is a compile-time error.

Reset
REQ-019 SHALL, while clr is high, hold hc=0, vc=0, hsync=1, vsync=1, red/green/blue=0, frame_start=0, active=0, and clear the stage-1 and stage-2 registers and the shadow enables.
REQ-020 SHALL, when clr is asserted mid-frame, take effect at the next dclk edge; the first post-reset output is hc=0,vc=0 after 2 cycles, with frame_start asserted.

Structure
REQ-021 SHALL place RGB332 field widths, the default timing constants and the sprite index helper in the shared package vga_pkg.
REQ-022 SHALL use a sub-module vga_timing_gen (counters, raw syncs, visible flag, px/py, frame flag); the renderer instantiates it and owns the shadow registers, hit logic and pipeline.

Verification
REQ-023 Default parameters, no sprites -> hsync period 800 cycles, low 96; vsync period 416800 cycles, low 1600; frame_start every 416800 cycles.
REQ-024 Sprite0 (10,20)-(19,29) rgb 0xE3 enabled, bg 0xFF -> exactly 100 pixels of 0xE3 per frame at px 10..19, py 20..29; all other visible pixels 0xFF; blanking 0.
REQ-025 Sprite0 (0,0)-(50,50) 0x03 and sprite1 (40,40)-(60,60) 0x1C overlap -> (45,45) outputs 0x03 and (55,55) outputs 0x1C.
REQ-026 Move sprite0 x from 100 to 200 at mid-frame (vc=200) -> current frame still shows x=100; next frame shows x=200.
REQ-027 Sprite with x_end=5<x=9 enabled, plus sprite at (639,479)-(639,479) -> first never drawn; second draws a single pixel at the last visible position.
REQ-028 clr pulsed 1 cycle at vc=300 -> outputs at reset values next cycle; frame_start 2 cycles after clr deasserts; timing then identical to REQ-023.
